// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table capture block: sizes, FSM states and
// the rule mapping the FUT input pattern onto a truth-table bit index.
package tt_pkg;

  localparam int N_IN    = 7;
  localparam int TT_BITS = 128;
  localparam int CNT_W   = 8;

  localparam logic [N_IN-1:0] LAST_PATTERN = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Table bit for pattern x is simply its binary value {x6..x0}.
  function automatic logic [N_IN-1:0] tt_index(input logic [N_IN-1:0] pattern);
    return pattern;
  endfunction

endpackage

// File: rtl/truth_table_capture.sv
// Walks all 128 input patterns of a 7-input function under test, sampling its
// output into a truth table and on-set count, then holds the result for a consumer.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic [N_IN-1:0]    x,
  input  logic               f,
  output logic [TT_BITS-1:0] tt,
  output logic [CNT_W-1:0]   ones,
  output logic               tt_valid,
  input  logic               tt_ready
);

  localparam int unsigned  SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE_M1);
  localparam state_t       AFTER_DRIVE = (SETTLE == 0) ? SAMPLE : DRIVE;

  state_t               state_q, state_d;
  logic [N_IN-1:0]      x_q, x_d;
  logic [TT_BITS-1:0]   tt_q, tt_d;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic [3:0]           settle_q, settle_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    tt_d     = tt_q;
    ones_d   = ones_q;
    settle_d = settle_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = '0;
          tt_d     = '0;
          ones_d   = '0;
          settle_d = '0;
          state_d  = AFTER_DRIVE;
        end
      end

      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      SAMPLE: begin
        tt_d[tt_index(x_q)] = f;
        ones_d              = ones_q + CNT_W'(f);
        if (x_q == LAST_PATTERN) begin
          state_d = HOLD;
        end else begin
          x_d     = x_q + 7'd1;
          state_d = AFTER_DRIVE;
        end
      end

      HOLD: begin
        // A ready completes the handshake; a simultaneous start is dropped.
        if (tt_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      tt_q     <= '0;
      ones_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      tt_q     <= tt_d;
      ones_q   <= ones_d;
      settle_q <= settle_d;
    end
  end

  assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);
  assign tt_valid = (state_q == HOLD);
  assign x        = x_q;
  assign tt       = tt_q;
  assign ones     = ones_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Self-checking bench: two captures units (SETTLE=0 and SETTLE=3) driven by a
// selectable function under test, checked against a table built from that function.
module tb_truth_table_capture;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_w    [2];
  logic         tt_ready_w [2];
  logic         busy_w     [2];
  logic [6:0]   x_w        [2];
  logic         f_w        [2];
  logic [127:0] tt_w       [2];
  logic [7:0]   ones_w     [2];
  logic         valid_w    [2];

  int           fut_mode;
  logic [127:0] rand_tbl;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 0: f=0, 1: f=x0, 2: maj(x0,x1,x2), 3: f=1, 4: arbitrary table lookup
  function automatic logic fut_eval(input int mode, input logic [127:0] tbl, input logic [6:0] xi);
    case (mode)
      0:       return 1'b0;
      1:       return xi[0];
      2:       return (xi[0] & xi[1]) | (xi[0] & xi[2]) | (xi[1] & xi[2]);
      3:       return 1'b1;
      default: return tbl[xi];
    endcase
  endfunction

  assign f_w[0] = fut_eval(fut_mode, rand_tbl, x_w[0]);
  assign f_w[1] = fut_eval(fut_mode, rand_tbl, x_w[1]);

  truth_table_capture #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .busy(busy_w[0]), .x(x_w[0]),
    .f(f_w[0]), .tt(tt_w[0]), .ones(ones_w[0]), .tt_valid(valid_w[0]), .tt_ready(tt_ready_w[0])
  );

  truth_table_capture #(.SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .busy(busy_w[1]), .x(x_w[1]),
    .f(f_w[1]), .tt(tt_w[1]), .ones(ones_w[1]), .tt_valid(valid_w[1]), .tt_ready(tt_ready_w[1])
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected table and on-set size, evaluated pattern by pattern from the FUT.
  task automatic model(input int mode, output logic [127:0] exp_tt, output int exp_ones);
    exp_tt   = '0;
    exp_ones = 0;
    for (int i = 0; i < 128; i++) begin
      exp_tt[i] = fut_eval(mode, rand_tbl, 7'(i));
      exp_ones += int'(exp_tt[i]);
    end
  endtask

  task automatic wait_valid(input int d, input int budget, output int n, output bit busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    while (n < budget) begin
      tick();
      n++;
      if (valid_w[d]) break;
      if (!busy_w[d]) busy_ok = 1'b0;
    end
  endtask

  // Full capture on unit d with FUT 'mode'; checks latency, busy and result.
  task automatic capture(input int d, input int mode, input string name);
    logic [127:0] exp_tt;
    int           exp_ones;
    int           n;
    bit           busy_ok;
    int           lat;
    fut_mode = mode;
    model(mode, exp_tt, exp_ones);
    lat = 128 * (settle_of(d) + 1);
    start_w[d] = 1'b1;
    tick();
    start_w[d] = 1'b0;
    vectors++;
    if (busy_w[d] !== 1'b1 || x_w[d] !== 7'd0) begin
      miscompares++;
      $display("FAIL %s accept: busy=%b x=%0d required busy=1 x=0", name, busy_w[d], x_w[d]);
    end
    wait_valid(d, lat + 20, n, busy_ok);
    vectors++;
    if (n !== lat || !busy_ok || valid_w[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s latency: edges=%0d busy_ok=%0b required edges=%0d", name, n, busy_ok, lat);
    end
    vectors++;
    if (tt_w[d] !== exp_tt || ones_w[d] !== 8'(exp_ones) || busy_w[d] !== 1'b0 || x_w[d] !== 7'd127) begin
      miscompares++;
      $display("FAIL %s result: tt=%h ones=%0d busy=%b x=%0d required tt=%h ones=%0d busy=0 x=127",
               name, tt_w[d], ones_w[d], busy_w[d], x_w[d], exp_tt, exp_ones);
    end
    $display("capture %s unit=%0d tt=%h ones=%0d edges=%0d", name, d, tt_w[d], ones_w[d], n);
  endtask

  task automatic release_table(input int d, input string name);
    logic [127:0] saved_tt;
    logic [7:0]   saved_ones;
    saved_tt   = tt_w[d];
    saved_ones = ones_w[d];
    tt_ready_w[d] = 1'b1;
    tick();
    tt_ready_w[d] = 1'b0;
    vectors++;
    if (valid_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || tt_w[d] !== saved_tt || ones_w[d] !== saved_ones) begin
      miscompares++;
      $display("FAIL %s release: valid=%b busy=%b tt=%h ones=%0d required valid=0 busy=0 tt=%h ones=%0d",
               name, valid_w[d], busy_w[d], tt_w[d], ones_w[d], saved_tt, saved_ones);
    end
    tick();
    vectors++;
    if (valid_w[d] !== 1'b0 || tt_w[d] !== saved_tt) begin
      miscompares++;
      $display("FAIL %s idle_keep: valid=%b tt=%h required valid=0 tt=%h", name, valid_w[d], tt_w[d], saved_tt);
    end
  endtask

  task automatic check_cleared(input int d, input string name);
    vectors++;
    if (busy_w[d] !== 1'b0 || valid_w[d] !== 1'b0 || x_w[d] !== 7'd0 || tt_w[d] !== '0 || ones_w[d] !== 8'd0) begin
      miscompares++;
      $display("FAIL %s: busy=%b valid=%b x=%0d tt=%h ones=%0d required all zero",
               name, busy_w[d], valid_w[d], x_w[d], tt_w[d], ones_w[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_cleared(0, "reset_u0");
    check_cleared(1, "reset_u1");
    rst_n = 1'b1;
    tick();
    $display("reset applied to both units");
  endtask

  task automatic test_const_zero();
    capture(0, 0, "const0");
    release_table(0, "const0");
  endtask

  task automatic test_x0();
    logic [127:0] golden;
    golden = {8{16'hAAAA}};
    capture(0, 1, "x0");
    vectors++;
    if (tt_w[0] !== golden || ones_w[0] !== 8'd64) begin
      miscompares++;
      $display("FAIL x0_golden: tt=%h ones=%0d required tt=%h ones=64", tt_w[0], ones_w[0], golden);
    end
    release_table(0, "x0");
  endtask

  task automatic test_maj_settle();
    logic [127:0] golden;
    golden = {16{8'hE8}};
    capture(1, 2, "maj_s3");
    vectors++;
    if (tt_w[1] !== golden || ones_w[1] !== 8'd64) begin
      miscompares++;
      $display("FAIL maj_golden: tt=%h ones=%0d required tt=%h ones=64", tt_w[1], ones_w[1], golden);
    end
    release_table(1, "maj_s3");
  endtask

  task automatic test_handshake();
    logic [127:0] saved;
    int           n;
    bit           busy_ok;
    rand_tbl = {$urandom, $urandom, $urandom, $urandom};
    capture(0, 4, "hs");
    saved = tt_w[0];
    for (int i = 0; i < 10; i++) begin
      start_w[0]    = i[0];
      tt_ready_w[0] = 1'b0;
      tick();
      vectors++;
      if (valid_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || tt_w[0] !== saved || x_w[0] !== 7'd127) begin
        miscompares++;
        $display("FAIL hold_%0d: valid=%b busy=%b x=%0d tt=%h required valid=1 busy=0 x=127 tt=%h",
                 i, valid_w[0], busy_w[0], x_w[0], tt_w[0], saved);
      end
    end
    start_w[0]    = 1'b1;
    tt_ready_w[0] = 1'b1;
    tick();
    start_w[0]    = 1'b0;
    tt_ready_w[0] = 1'b0;
    vectors++;
    if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || tt_w[0] !== saved) begin
      miscompares++;
      $display("FAIL hs_start_ignored: valid=%b busy=%b tt=%h required valid=0 busy=0 tt=%h",
               valid_w[0], busy_w[0], tt_w[0], saved);
    end
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    vectors++;
    if (busy_w[0] !== 1'b1 || tt_w[0] !== '0 || ones_w[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL hs_restart_clear: busy=%b tt=%h ones=%0d required busy=1 tt=0 ones=0",
               busy_w[0], tt_w[0], ones_w[0]);
    end
    wait_valid(0, 200, n, busy_ok);
    vectors++;
    if (valid_w[0] !== 1'b1 || n !== 128) begin
      miscompares++;
      $display("FAIL hs_recapture: valid=%b edges=%0d required valid=1 edges=128", valid_w[0], n);
    end
    $display("handshake held 10 cycles, recapture tt=%h", tt_w[0]);
    release_table(0, "hs");
  endtask

  task automatic test_reset_mid();
    int n;
    fut_mode   = 3;
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    n = 0;
    while (x_w[0] !== 7'd60 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (x_w[0] !== 7'd60 || ones_w[0] !== 8'd60) begin
      miscompares++;
      $display("FAIL mid_reach60: x=%0d ones=%0d required x=60 ones=60", x_w[0], ones_w[0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_cleared(0, "mid_reset");
    tick();
    check_cleared(0, "mid_reset_idle");
    $display("reset at pattern 60 cleared the capture");
    capture(0, 3, "all_ones");
    vectors++;
    if (tt_w[0] !== {128{1'b1}} || ones_w[0] !== 8'd128) begin
      miscompares++;
      $display("FAIL all_ones_golden: tt=%h ones=%0d required all ones, ones=128", tt_w[0], ones_w[0]);
    end
    release_table(0, "all_ones");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      rand_tbl = {$urandom, $urandom, $urandom, $urandom};
      if (k == 5) rand_tbl = rand_tbl & {$urandom, $urandom, $urandom, $urandom};
      capture(k % 2, 4, $sformatf("rand%0d", k));
      release_table(k % 2, $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start_w[0]    = 1'b0;
    start_w[1]    = 1'b0;
    tt_ready_w[0] = 1'b0;
    tt_ready_w[1] = 1'b0;
    fut_mode      = 0;
    rand_tbl      = '0;
    test_reset();
    test_const_zero();
    test_x0();
    test_maj_settle();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
